// File: rtl/fb_pkg.sv
// Shared constants and writer state encoding for the ping-pong frame store.
// Default geometry is 320x240; the top level recomputes sizes from its own parameters.
package fb_pkg;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  // One extra code above the last pixel keeps out-of-range read addresses representable
  // even when the frame size is a power of two.
  function automatic int fb_addr_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int NUM_PIXELS = H_RES_DEF * V_RES_DEF;
  localparam int ADDR_W     = fb_addr_w(NUM_PIXELS);

  typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_DONE} wr_state_t;

endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM with a single write port and a registered read port.
module fb_bank
  import fb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/framebuffer_pingpong.sv
// Double-buffered frame store: raster writer fills the back bank, reader scans the front bank,
// banks swap only on rd_vsync with a complete frame pending. Option macro: FB_DROP_COUNT_EN.
module framebuffer_pingpong
  import fb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  localparam int PIX_N  = H_RES * V_RES,
  localparam int PIX_AW = fb_addr_w(PIX_N)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_sof,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PIX_AW-1:0] rd_addr,
  input  logic              rd_vsync,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              front_bank,
  output logic              frame_pending,
  output logic              wr_busy
`ifdef FB_DROP_COUNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int BAW = (PIX_N > 1) ? $clog2(PIX_N) : 1;

  wr_state_t      state_q, state_d;
  logic [BAW-1:0] ptr_q, ptr_d, wr_addr;
  logic           front_q, front_d, pend_q, pend_d, busy_q, busy_d;
  logic           wr_en, swap;

  assign swap = rd_vsync & pend_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    front_d = front_q;
    pend_d  = pend_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    case (state_q)
      WR_IDLE: begin
        if (wr_sof) begin
          state_d = WR_ACTIVE;
          ptr_d   = '0;
        end
      end
      WR_ACTIVE: begin
        if (wr_sof) begin
          // Restart: a pixel arriving with sof is the first pixel of the new frame.
          wr_en   = wr_valid;
          wr_addr = '0;
          ptr_d   = wr_valid ? BAW'(1) : '0;
        end else if (wr_valid) begin
          wr_en = 1'b1;
          if (ptr_q == BAW'(PIX_N - 1)) begin
            state_d = WR_DONE;
            pend_d  = 1'b1;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      WR_DONE: begin
        if (swap) begin
          front_d = ~front_q;
          pend_d  = 1'b0;
          ptr_d   = '0;
          state_d = wr_sof ? WR_ACTIVE : WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
    busy_d = (state_d == WR_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WR_IDLE;
      ptr_q   <= '0;
      front_q <= 1'b1;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
    end
  end

  assign front_bank    = front_q;
  assign frame_pending = pend_q;
  assign wr_busy       = busy_q;

  // Read path: both banks read at issue; the bank select travels with the request so a swap
  // between issue and return cannot change the data.
  logic              rd_oob;
  logic [BAW-1:0]    rd_baddr;
  logic [DATA_W-1:0] bank_q [2];

  assign rd_oob   = (rd_addr >= PIX_AW'(PIX_N));
  assign rd_baddr = rd_oob ? '0 : rd_addr[BAW-1:0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank #(.DEPTH(PIX_N), .DATA_W(DATA_W)) u_bank (
      .clk   (clk),
      .we    (wr_en && (front_q != 1'(b))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (rd_en),
      .raddr (rd_baddr),
      .rdata (bank_q[b])
    );
  end

  logic              s1_vld_q, s1_vld_d, s1_bank_q, s1_bank_d, s1_oob_q, s1_oob_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    s1_vld_d   = rd_en;
    s1_bank_d  = rd_en ? front_q : s1_bank_q;
    s1_oob_d   = rd_en ? rd_oob : s1_oob_q;
    rd_valid_d = s1_vld_q;
    rd_data_d  = rd_data_q;
    if (s1_vld_q) rd_data_d = s1_oob_q ? '0 : bank_q[s1_bank_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_bank_q  <= 1'b0;
      s1_oob_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_bank_q  <= s1_bank_d;
      s1_oob_q   <= s1_oob_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef FB_DROP_COUNT_EN
  // A drop is any sof that abandons a partial frame or hits a held frame outside a swap.
  logic        drop_evt;
  logic [15:0] drop_q, drop_d;

  assign drop_evt = wr_sof && ((state_q == WR_ACTIVE) || ((state_q == WR_DONE) && !swap));

  always_comb begin
    drop_d = drop_q;
    if (drop_evt && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

endmodule
